// File: rtl/qupls_reglist_seq.sv
// rtl/qupls_reglist_seq.sv - register bit-list sequencer feeding iRn0..iRn3 of the extract stage.
// Optional feature: QUPLS_REGLIST_REVERSE_EN enables descending (highest-first) scan selected by rev_i.
module qupls_reglist_seq #(
  parameter int NREG = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [NREG-1:0] mask_i,
  input  logic            rev_i,
  output logic [6:0]      iRn0_o,
  output logic [6:0]      iRn1_o,
  output logic [6:0]      iRn2_o,
  output logic [6:0]      iRn3_o,
  output logic [6:0]      regcnt_o,
  output logic            stall_o,
  output logic            done_o,
  output logic            irq_ok_o
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t          st;
  state_t          st_next;
  logic [NREG-1:0] rem;
  logic [NREG-1:0] rem_next;
  logic [NREG-1:0] work;
  logic [6:0]      grp  [4];
  logic [6:0]      lane [4];
  logic [6:0]      regcnt;
  logic            done;
  logic            hit;
  logic            accept;

`ifdef QUPLS_REGLIST_REVERSE_EN
  logic rev_q;
  logic scan_rev;
  // Direction is taken live from rev_i on the start cycle, then from the latched copy.
  assign scan_rev = (st == IDLE) ? rev_i : rev_q;
`else
  logic unused_rev;
  assign unused_rev = rev_i;
`endif

  assign accept = en_i & start_i & (|mask_i);

  // Peel up to four set bits from the source mask in scan order.
  always_comb begin
    work = (st == IDLE) ? mask_i : rem;
    hit  = 1'b0;
    for (int l = 0; l < 4; l++) begin
      grp[l] = 7'h7F;
      hit    = 1'b0;
`ifdef QUPLS_REGLIST_REVERSE_EN
      if (scan_rev) begin
        for (int j = NREG - 1; j >= 0; j--) begin
          if (!hit && work[j]) begin
            hit     = 1'b1;
            grp[l]  = 7'(j);
            work[j] = 1'b0;
          end
        end
      end else
`endif
      begin
        for (int j = 0; j < NREG; j++) begin
          if (!hit && work[j]) begin
            hit     = 1'b1;
            grp[l]  = 7'(j);
            work[j] = 1'b0;
          end
        end
      end
    end
    rem_next = work;
  end

  always_comb begin
    st_next = st;
    if (flush_i) begin
      st_next = IDLE;
    end else if (en_i) begin
      case (st)
        IDLE:    if (accept && (|rem_next)) st_next = EXPAND;
        EXPAND:  if (~|rem_next) st_next = IDLE;
        default: st_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) st <= IDLE;
    else       st <= st_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rem    <= '0;
      regcnt <= 7'd0;
      done   <= 1'b0;
      for (int l = 0; l < 4; l++) lane[l] <= 7'h7F;
`ifdef QUPLS_REGLIST_REVERSE_EN
      rev_q  <= 1'b0;
`endif
    end else if (en_i) begin
      if (st == IDLE) begin
        if (start_i) begin
          // An empty list still pulses done so the instruction passes through unexpanded.
          for (int l = 0; l < 4; l++) lane[l] <= grp[l];
          regcnt <= 7'd0;
          rem    <= rem_next;
          done   <= ~|rem_next;
`ifdef QUPLS_REGLIST_REVERSE_EN
          rev_q  <= rev_i;
`endif
        end else begin
          for (int l = 0; l < 4; l++) lane[l] <= 7'h7F;
          done <= 1'b0;
        end
      end else begin
        for (int l = 0; l < 4; l++) lane[l] <= grp[l];
        regcnt <= (regcnt > 7'd123) ? 7'h7F : regcnt + 7'd4;
        rem    <= rem_next;
        done   <= ~|rem_next;
      end
    end
  end

  // Fetch is held during expansion, so a new start here means the stall was ignored upstream.
  always @(posedge clk_i) begin
    if (!rst_i && !flush_i && st == EXPAND) assert (!start_i);
  end

  assign iRn0_o   = lane[0];
  assign iRn1_o   = lane[1];
  assign iRn2_o   = lane[2];
  assign iRn3_o   = lane[3];
  assign regcnt_o = regcnt;
  assign done_o   = done;
  assign stall_o  = (st == EXPAND);
  assign irq_ok_o = (st == IDLE) && (lane[0] == 7'h7F) && (lane[1] == 7'h7F)
                    && (lane[2] == 7'h7F) && (lane[3] == 7'h7F);

endmodule

// File: tb/tb_qupls_reglist_seq.sv
// tb/tb_qupls_reglist_seq.sv - scoreboard bench for qupls_reglist_seq with directed steps.
module tb_qupls_reglist_seq;

  logic        clk = 1'b0;
  logic        rst, en, flush, start, rev;
  logic [63:0] mask;
  logic [6:0]  r0, r1, r2, r3, regcnt;
  logic        stall, done, irq_ok;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [6:0] l0, l1, l2, l3;
    int         cnt;
    logic       stall, done, irq;
  } exp_t;

  exp_t sb[$];

  qupls_reglist_seq #(.NREG(64)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .start_i(start),
    .mask_i(mask), .rev_i(rev),
    .iRn0_o(r0), .iRn1_o(r1), .iRn2_o(r2), .iRn3_o(r3),
    .regcnt_o(regcnt), .stall_o(stall), .done_o(done), .irq_ok_o(irq_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int l0, input int l1, input int l2, input int l3,
                      input int cnt, input bit s, input bit d, input bit i);
    exp_t e;
    e.tag = tag; e.l0 = 7'(l0); e.l1 = 7'(l1); e.l2 = 7'(l2); e.l3 = 7'(l3);
    e.cnt = cnt; e.stall = s; e.done = d; e.irq = i;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".l0"}, int'(r0), int'(e.l0));
    chk({e.tag, ".l1"}, int'(r1), int'(e.l1));
    chk({e.tag, ".l2"}, int'(r2), int'(e.l2));
    chk({e.tag, ".l3"}, int'(r3), int'(e.l3));
    if (e.cnt >= 0) chk({e.tag, ".regcnt"}, int'(regcnt), e.cnt);
    chk({e.tag, ".stall"}, int'(stall), int'(e.stall));
    chk({e.tag, ".done"}, int'(done), int'(e.done));
    chk({e.tag, ".irq_ok"}, int'(irq_ok), int'(e.irq));
  endtask

  // One clock edge, then compare the DUT against the oldest expectation.
  task automatic tick();
    @(posedge clk);
    #1;
    compare_front();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; start = 1'b0; rev = 1'b0; mask = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push("reset", 127, 127, 127, 127, 0, 0, 0, 1);
    compare_front();

    // Two-group expansion of 0x00F1.
    en = 1'b1; start = 1'b1; mask = 64'h00F1;
    push("f1_g1", 0, 4, 5, 6, 0, 1, 0, 0);
    tick();
    start = 1'b0; mask = '0;
    push("f1_g2", 7, 127, 127, 127, 4, 0, 1, 0);
    tick();
    push("f1_idle", 127, 127, 127, 127, 4, 0, 0, 1);
    tick();

    // Empty list passes through with a single done pulse.
    start = 1'b1; mask = '0;
    push("zero_start", 127, 127, 127, 127, -1, 0, 1, 1);
    tick();
    start = 1'b0;
    push("zero_after", 127, 127, 127, 127, -1, 0, 0, 1);
    tick();

    // Full 64-bit mask: sixteen groups.
    start = 1'b1; mask = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int g = 0; g < 16; g++) begin
      push($sformatf("full_g%0d", g), 4*g, 4*g+1, 4*g+2, 4*g+3, 4*g, g < 15, g == 15, 0);
      tick();
      start = 1'b0; mask = '0;
    end
    push("full_idle", 127, 127, 127, 127, 60, 0, 0, 1);
    tick();

    // Single group, then enable gap: everything holds.
    start = 1'b1; mask = 64'h1_0001_0001;
    push("gap_g1", 0, 16, 32, 127, 0, 0, 1, 0);
    tick();
    start = 1'b0; mask = '0; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push($sformatf("gap_hold%0d", k), 0, 16, 32, 127, 0, 0, 1, 0);
      tick();
    end
    en = 1'b1;
    push("gap_resume", 127, 127, 127, 127, 0, 0, 0, 1);
    tick();

    // Flush during group 2 of 0x00FF_FFFF, with a hold cycle inside the expansion.
    start = 1'b1; mask = 64'h00FF_FFFF;
    push("fl_g1", 0, 1, 2, 3, 0, 1, 0, 0);
    tick();
    start = 1'b0; mask = '0; en = 1'b0;
    push("fl_hold", 0, 1, 2, 3, 0, 1, 0, 0);
    tick();
    en = 1'b1;
    push("fl_g2", 4, 5, 6, 7, 4, 1, 0, 0);
    tick();
    flush = 1'b1;
    push("fl_abort", 127, 127, 127, 127, 0, 0, 0, 1);
    tick();
    flush = 1'b0; start = 1'b1; mask = 64'h3;
    push("fl_restart", 0, 1, 127, 127, 0, 0, 1, 0);
    tick();
    start = 1'b0; mask = '0;
    push("fl_idle", 127, 127, 127, 127, 0, 0, 0, 1);
    tick();

`ifdef QUPLS_REGLIST_REVERSE_EN
    start = 1'b1; rev = 1'b1; mask = 64'h8000_0000_0000_0013;
    push("rev_g1", 63, 4, 1, 0, 0, 0, 1, 0);
    tick();
    start = 1'b0; rev = 1'b0; mask = '0;
    push("rev_idle", 127, 127, 127, 127, 0, 0, 0, 1);
    tick();
`endif

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
